// File: rtl/mppt_pkg.sv
// Shared types, default parameters and the duty-step decision for the
// perturb-and-observe MPPT tracker.
//
// Contents:
//   state_e     - tracker FSM states (idle, calc, decide, settle)
//   step_sel_e  - outcome of one duty perturbation (step or clamp)
//   Def*        - default parameter values used by the tracker top
//   duty_step() - saturating duty-step decision, evaluated wider than the
//                 duty register so duty+step can never wrap
package mppt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDecide,
        StSettle
    } state_e;

    typedef enum logic [1:0] {
        SelUp,
        SelDown,
        SelClampHi,
        SelClampLo
    } step_sel_e;

    localparam int unsigned DefDw       = 8;
    localparam int unsigned DefDutyW    = 8;
    localparam int unsigned DefStep     = 4;
    localparam int unsigned DefDutyMin  = 16;
    localparam int unsigned DefDutyMax  = 240;
    localparam int unsigned DefDutyInit = 128;
    localparam int unsigned DefSettle   = 16;

    // Decide how the duty moves for direction d. Reaching a clamp also
    // reverses the direction, which the caller applies.
    function automatic step_sel_e duty_step(input logic [31:0] duty,
                                            input logic        d,
                                            input logic [31:0] step,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        if (d) begin
            return (duty + step > hi) ? SelClampHi : SelUp;
        end
        return (duty < lo + step) ? SelClampLo : SelDown;
    endfunction

endpackage

// File: rtl/mppt_pwm.sv
// PWM generator driving the converter power stage.
//
// A free-running DUTY_W-bit counter is compared against a latched copy of
// the duty command. The copy only reloads when the counter wraps from
// all-ones to zero, so a duty change never cuts a period short.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   duty_i  - duty command from the tracker
//   pwm_o   - PWM drive, high for duty_act cycles of every 2^DUTY_W
module mppt_pwm #(
    parameter int unsigned DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_o
);

    logic [DUTY_W-1:0] cnt_q;
    logic [DUTY_W-1:0] duty_act_q;

    // duty_act resets to 0 so the output stays low until the first wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            duty_act_q <= '0;
        end else begin
            cnt_q <= cnt_q + DUTY_W'(1);
            if (&cnt_q) begin
                duty_act_q <= duty_i;
            end
        end
    end

    assign pwm_o = (cnt_q < duty_act_q);

endmodule

// File: rtl/mppt_po_tracker.sv
// Perturb-and-observe maximum-power-point tracker.
//
// Takes voltage/current sample pairs over a valid/ready handshake, forms
// the full-width power product, compares it with the previous power and
// steps the converter duty toward the maximum, then waits a settle window
// before taking the next sample.
//
// Build option: define MPPT_PWM_EN to instantiate the PWM generator;
// otherwise pwm_out is tied low.
//
// Ports:
//   clk, rst_n       - clock and asynchronous active-low reset
//   ena              - gates sample acceptance in IDLE only
//   v_in, i_in       - unsigned voltage / current samples
//   s_valid, s_ready - sample handshake
//   duty             - registered duty command
//   dir              - perturbation direction, 1 = increase
//   p_last           - last computed power
//   update           - one-cycle pulse when duty/dir/p_last change
//   pwm_out          - PWM drive
module mppt_po_tracker
    import mppt_pkg::*;
#(
    parameter int unsigned DW        = DefDw,
    parameter int unsigned DUTY_W    = DefDutyW,
    parameter int unsigned STEP      = DefStep,
    parameter int unsigned DUTY_MIN  = DefDutyMin,
    parameter int unsigned DUTY_MAX  = DefDutyMax,
    parameter int unsigned DUTY_INIT = DefDutyInit,
    parameter int unsigned SETTLE    = DefSettle
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DW-1:0]     v_in,
    input  logic [DW-1:0]     i_in,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic [2*DW-1:0]   p_last,
    output logic              update,
    output logic              pwm_out
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e            state_q;
    logic [DW-1:0]     v_q;
    logic [DW-1:0]     i_q;
    logic [2*DW-1:0]   p_new_q;
    logic [2*DW-1:0]   p_last_q;
    logic [DUTY_W-1:0] duty_q;
    logic              dir_q;
    logic              update_q;
    logic              rdy_q;
    logic [CntW-1:0]   cnt_q;

    logic              dir_new;
    logic              dir_nxt;
    logic [DUTY_W-1:0] duty_nxt;

    // rdy_q is high exactly while the FSM sits in IDLE; ena gates it live
    // so dropping ena blocks acceptance on the very same cycle.
    assign s_ready = rdy_q & ena;

    always_comb begin
        dir_new  = (p_new_q < p_last_q) ? ~dir_q : dir_q;
        duty_nxt = duty_q;
        dir_nxt  = dir_new;
        case (duty_step(32'(duty_q), dir_new, STEP, DUTY_MIN, DUTY_MAX))
            SelClampHi: begin
                duty_nxt = DUTY_W'(DUTY_MAX);
                dir_nxt  = 1'b0;
            end
            SelClampLo: begin
                duty_nxt = DUTY_W'(DUTY_MIN);
                dir_nxt  = 1'b1;
            end
            SelUp:   duty_nxt = duty_q + DUTY_W'(STEP);
            SelDown: duty_nxt = duty_q - DUTY_W'(STEP);
            default: duty_nxt = duty_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            v_q      <= '0;
            i_q      <= '0;
            p_new_q  <= '0;
            p_last_q <= '0;
            duty_q   <= DUTY_W'(DUTY_INIT);
            dir_q    <= 1'b1;
            update_q <= 1'b0;
            rdy_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (s_valid && s_ready) begin
                        v_q     <= v_in;
                        i_q     <= i_in;
                        rdy_q   <= 1'b0;
                        state_q <= StCalc;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                StCalc: begin
                    p_new_q <= (2*DW)'(v_q) * (2*DW)'(i_q);
                    state_q <= StDecide;
                end
                StDecide: begin
                    duty_q   <= duty_nxt;
                    dir_q    <= dir_nxt;
                    p_last_q <= p_new_q;
                    update_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= StSettle;
                end
                StSettle: begin
                    if (cnt_q == CntW'(SETTLE - 1)) begin
                        rdy_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign duty   = duty_q;
    assign dir    = dir_q;
    assign p_last = p_last_q;
    assign update = update_q;

`ifdef MPPT_PWM_EN
    mppt_pwm #(
        .DUTY_W(DUTY_W)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .duty_i(duty_q),
        .pwm_o (pwm_out)
    );
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: doc/mppt_po_tracker.md
# mppt_po_tracker

Parametrised perturb-and-observe maximum-power-point tracker for the renewable-energy converter datapath. Accepts voltage/current sample pairs over a valid/ready handshake, computes instantaneous power, and nudges a converter duty cycle toward the power maximum. A settle window separates perturbations. An optional on-block PWM generator drives the power stage.

## Interface
Parameters:
- `DW`, 8: width of the voltage and current samples, unsigned.
- `DUTY_W`, 8: duty-cycle width; PWM period is 2^DUTY_W cycles.
- `STEP`, 4: duty increment per perturbation.
- `DUTY_MIN`, 16: lower duty clamp.
- `DUTY_MAX`, 240: upper duty clamp.
- `DUTY_INIT`, 128: duty after reset. Must satisfy DUTY_MIN ≤ DUTY_INIT ≤ DUTY_MAX.
- `SETTLE`, 16: cycles spent in SETTLE after each update (≥1).

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `ena`, in, 1: enable. While low, no new samples are accepted.
- `v_in`, in, DW: voltage sample.
- `i_in`, in, DW: current sample.
- `s_valid`, in, 1: sample pair is valid.
- `s_ready`, out, 1: block will accept a sample.
- `duty`, out, DUTY_W: current duty command (registered).
- `dir`, out, 1: perturbation direction. 1 = increase.
- `p_last`, out, 2·DW: last computed power (registered).
- `update`, out, 1: one-cycle pulse when duty/dir/p_last change.
- `pwm_out`, out, 1: PWM drive.

## Operation
- FSM states: IDLE → CALC → DECIDE → SETTLE → IDLE.
- **IDLE**
  - `s_ready = ena`.
  - On `s_valid & s_ready`, register v_in and i_in, then go to CALC.
- **CALC**
  - `p_new <= v·i`, full 2·DW-bit unsigned product with no truncation.
  - Go to DECIDE.
- **DECIDE**
  - Direction: if p_new < p_last, invert dir; otherwise (greater or equal) keep dir.
  - With the resulting direction d, compute in DUTY_W+1 bits:
    - d=1 and duty+STEP > DUTY_MAX: duty=DUTY_MAX, dir=0.
    - d=0 and duty < DUTY_MIN+STEP: duty=DUTY_MIN, dir=1.
    - Otherwise: duty ± STEP, dir=d.
  - `p_last <= p_new`. `update` is high for exactly one cycle.
  - Go to SETTLE.
- **SETTLE**
  - Counter runs 0..SETTLE-1. `s_ready=0`.
  - Return to IDLE after SETTLE cycles.
- `ena` deassertion only gates acceptance in IDLE. A sample already in flight completes CALC/DECIDE/SETTLE normally.
- The first sample after reset compares against p_last=0, so the direction is always kept (up).

## Timing
- Reset values:
  - duty=DUTY_INIT, dir=1, p_last=0, update=0, s_ready=0.
  - FSM in IDLE; PWM counter 0; pwm_out=0.
  - `s_ready` may rise on the first cycle after release if ena=1.
- Acceptance edge is E0. p_new is registered at E1. duty, dir, p_last and update are registered at E2.
- s_ready drops after E0. It returns high SETTLE+2 cycles after E0, giving a minimum sample period of SETTLE+3 cycles.
- `s_valid` held while s_ready=0 is not consumed. The pair is taken on the first cycle that s_ready=1.
- Reset asserted mid-operation forces reset values immediately. The in-flight sample is discarded.

## Configuration
- Macro: `MPPT_PWM_EN`.
- Defined:
  - Free-running DUTY_W-bit counter; `pwm_out = (cnt < duty_act)`.
  - duty_act loads `duty` when cnt wraps from all-ones to 0, so a duty change takes effect only at the next period start (glitch-free).
  - duty=0 gives constant low. High time per period equals duty_act cycles.
- Undefined: no counter is instantiated and `pwm_out` is tied 0. All other behaviour is unchanged.

## Structure
- Package `mppt_pkg`:
  - FSM state enum (IDLE, CALC, DECIDE, SETTLE).
  - Default parameter constants.
  - Saturating duty-step function.
- Sub-module `mppt_pwm`, parametrised by DUTY_W: counter, period-boundary duty latch, comparator. Instantiated only under MPPT_PWM_EN.

## Test plan
Defaults throughout unless stated; MPPT_PWM_EN defined.
1. Reset: hold rst_n=0 mid-run → duty=128, dir=1, p_last=0, update=0, s_ready=0, pwm_out=0 asynchronously.
2. First sample: v=150, i=10 accepted at E0 → at E2 p_last=1500, duty=132, dir=1, update high exactly one cycle; s_ready high again at E0+18.
3. Power drop: next sample v=140, i=10 (1400<1500) → dir=0, duty=128. Then v=140, i=10 (equal) → dir stays 0, duty=124.
4. Saturation: DUTY_INIT=236, two rising-power samples (1000, 2000) → duty 240, dir=1, then duty 240, dir=0. Mirror case at DUTY_MIN=16 → duty 16, dir=1.
5. Handshake/enable: s_valid held through SETTLE → exactly one acceptance per SETTLE+3 cycles. ena=0 in IDLE → s_ready=0, no update. ena dropped during CALC → that update still occurs.
6. PWM: duty=64 → pwm_out high 64 of every 256 cycles. A duty change mid-period applies from the next counter wrap. With MPPT_PWM_EN undefined, pwm_out stays 0.
